stride_counter: RTL and testbench
=================================

Name: stride_counter

Overview:
- Parametrised successor to the fixed 4-bit odd-value counter. Steps through the arithmetic sequence START, START+STEP, … up to the largest value that fits in WIDTH bits.
- Adds the following, none of which the fixed counter has:
  - enable and direction control
  - selectable boundary mode: wrap, saturate or bounce
  - synchronous load with alignment to a legal value
  - status flags
- Used wherever the design needs a sequence generator (odd-only, multiples-of-N, or even-only index), driven from a control FSM.

Parameters:
- WIDTH, 4: counter width in bits. Range 2..16.
- START, 1: lowest legal value (LO). Range 0 ≤ START ≤ 2^WIDTH−1.
- STEP, 2: increment between legal values. Range 1 ≤ STEP ≤ 2^WIDTH−1−START.
- Derived constant HI = START + STEP*((2^WIDTH−1−START)/STEP), the highest legal value. Defaults give LO=1, HI=15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- en  in  1  advance one step this cycle
- dir  in  1  1=up, 0=down; sampled in WRAP/SAT modes and on load
- mode  in  2  0=WRAP, 1=SAT, 2=BOUNCE, 3=reserved (treated as WRAP)
- load  in  1  load aligned load_val this cycle
- load_val  in  WIDTH  value to load
- count  out  WIDTH  current value, always a legal value
- edge  out  1  one-cycle pulse: a wrap or bounce reversal happened this step
- at_hi  out  1  count == HI
- at_lo  out  1  count == LO
- load_err  out  1  one-cycle pulse: load_val was not already legal

Behaviour:
- All outputs registered. Reset (reset==0 at a clk edge) gives:
  - count=LO, dir_q=1 (up)
  - edge=0, load_err=0, at_lo=1, at_hi=(LO==HI)
- Priority per cycle: reset > load > en > hold.
- Load:
  - count ← largest legal value ≤ load_val.
  - If load_val < LO, count ← LO.
  - If load_val > HI, count ← HI.
  - load_err=1 for one cycle when the loaded value differs from load_val.
  - dir_q ← dir. edge=0.
  - Example, defaults: load 6 → 5, load_err=1; load 0 → 1, load_err=1; load 9 → 9, load_err=0.
- Step (en=1, no load). Effective direction d = dir in WRAP/SAT, d = dir_q in BOUNCE. dir_q tracks dir every cycle outside BOUNCE.
  - Interior value: count ← count ± STEP; edge=0.
  - At HI going up:
    - WRAP: count ← LO, edge=1.
    - SAT: hold HI, edge=0.
    - BOUNCE: count ← HI−STEP, dir_q←0, edge=1.
  - At LO going down: mirror of the HI case (WRAP → HI; SAT hold; BOUNCE → LO+STEP, dir_q←1).
  - Degenerate LO==HI: count holds LO in every mode; edge=0.
- Arithmetic uses WIDTH+1 bits internally so HI+STEP cannot overflow silently. count never takes a non-legal value.
- en=0: count and dir_q hold, edge=0. load_err is 0 except in a load cycle.
- at_hi/at_lo are registered and reflect the next count in the same cycle count updates.
- Mode change mid-count takes effect on the next step. Entering BOUNCE continues in the current dir_q.
- Reset mid-sequence returns to LO in one cycle, regardless of en/load.
- Latency: one clk from input to count.

Decomposition:
- Package stride_counter_pkg:
  - mode encoding constants MODE_WRAP, MODE_SAT, MODE_BOUNCE
  - function computing HI from WIDTH/START/STEP
- One combinational sub-module, stride_next:
  - inputs: count, d, mode
  - outputs: next value, next dir_q, edge
- The top holds the registers and the load-alignment logic.

Test Plan:
- Reset low 1 cycle, then en=1, dir=1, mode=WRAP, defaults → count 1,3,5,…,15,1; edge=1 only on the 15→1 step.
- mode=SAT, dir=1 from 13 for 3 cycles → 15,15,15; at_hi=1, edge=0. Then dir=0 → 13.
- mode=BOUNCE from 13, en held → 15,13,11 (edge=1 on 15→13); at LO, 1→3 with edge=1.
- load=1, load_val=6 → count=5, load_err=1 for one cycle. load_val=0 → 1, load_err=1. load_val=9 → 9, load_err=0. Load and en together → load wins.
- WIDTH=5, START=0, STEP=3 → HI=30. WRAP up gives 0,3,…,30,0. WRAP down from 0 → 30 with edge=1.
- Assert reset during count=11 with en=1 and load=1 → next count=1, edge=0, load_err=0.

Source files
------------

// File: rtl/stride_counter_pkg.sv
// Shared mode encoding and legal-range helper for the stride counter.
package stride_counter_pkg;

    localparam logic [1:0] MODE_WRAP   = 2'd0;
    localparam logic [1:0] MODE_SAT    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;

    // Highest value reachable from start in whole steps without exceeding width bits.
    function automatic int stride_hi(input int width, input int start, input int step);
        return start + step * (((1 << width) - 1 - start) / step);
    endfunction

endpackage

// File: rtl/stride_next.sv
// Combinational successor of a legal count for one enabled step; no state, zero latency.
import stride_counter_pkg::*;

module stride_next #(
    parameter int WIDTH = 4,
    parameter int LO    = 1,
    parameter int HI    = 15,
    parameter int STEP  = 2
) (
    input  logic [WIDTH-1:0] count,
    input  logic             d,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] nxt,
    output logic             nxt_dir,
    output logic             edge_pulse
);

    localparam logic [WIDTH:0]   LO_W   = (WIDTH+1)'(LO);
    localparam logic [WIDTH:0]   HI_W   = (WIDTH+1)'(HI);
    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] LO_N   = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_N   = WIDTH'(HI);
    localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

    logic [WIDTH:0] up_w;
    logic           hit_top;
    logic           hit_bot;

    assign up_w    = {1'b0, count} + STEP_W;
    assign hit_top = d && (up_w > HI_W);
    assign hit_bot = !d && ({1'b0, count} < LO_W + STEP_W);

    always_comb begin
        nxt        = count;
        nxt_dir    = d;
        edge_pulse = 1'b0;
        if (LO == HI) begin
            nxt = count;
        end else if (hit_top || hit_bot) begin
            // Reserved mode 3 falls through to wrap behaviour.
            if (mode == MODE_SAT) begin
                nxt = count;
            end else if (mode == MODE_BOUNCE) begin
                nxt        = hit_top ? HI_N - STEP_N : LO_N + STEP_N;
                nxt_dir    = hit_bot;
                edge_pulse = 1'b1;
            end else begin
                nxt        = hit_top ? LO_N : HI_N;
                edge_pulse = 1'b1;
            end
        end else begin
            nxt = d ? up_w[WIDTH-1:0] : count - STEP_N;
        end
    end

endmodule

// File: rtl/stride_counter.sv
// Arithmetic-sequence counter with wrap/saturate/bounce boundaries and aligned load.
// One clock from en/load to count; all outputs registered. (edge is a reserved word, hence edge_pulse.)
import stride_counter_pkg::*;

module stride_counter #(
    parameter int WIDTH = 4,
    parameter int START = 1,
    parameter int STEP  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             edge_pulse,
    output logic             at_hi,
    output logic             at_lo,
    output logic             load_err
);

    localparam int               HI     = stride_hi(WIDTH, START, STEP);
    localparam logic [WIDTH-1:0] LO_N   = WIDTH'(START);
    localparam logic [WIDTH-1:0] HI_N   = WIDTH'(HI);
    localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

    logic             dir_q;
    logic             d;
    logic [WIDTH-1:0] step_val;
    logic             step_dir;
    logic             step_edge;
    logic [WIDTH-1:0] aligned;
    logic [WIDTH-1:0] count_d;
    logic             dir_d;
    logic             edge_d;
    logic             err_d;

    // Bounce owns its direction; the other modes follow the dir pin.
    assign d = (mode == MODE_BOUNCE) ? dir_q : dir;

    stride_next #(
        .WIDTH (WIDTH),
        .LO    (START),
        .HI    (HI),
        .STEP  (STEP)
    ) u_next (
        .count      (count),
        .d          (d),
        .mode       (mode),
        .nxt        (step_val),
        .nxt_dir    (step_dir),
        .edge_pulse (step_edge)
    );

    always_comb begin
        if (load_val < LO_N) begin
            aligned = LO_N;
        end else if (load_val > HI_N) begin
            aligned = HI_N;
        end else begin
            aligned = LO_N + ((load_val - LO_N) / STEP_N) * STEP_N;
        end
    end

    always_comb begin
        count_d = count;
        dir_d   = dir_q;
        edge_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            count_d = aligned;
            dir_d   = dir;
            err_d   = (aligned != load_val);
        end else if (en) begin
            count_d = step_val;
            dir_d   = step_dir;
            edge_d  = step_edge;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count      <= LO_N;
            dir_q      <= 1'b1;
            edge_pulse <= 1'b0;
            load_err   <= 1'b0;
            at_lo      <= 1'b1;
            at_hi      <= (START == HI);
        end else begin
            count      <= count_d;
            dir_q      <= dir_d;
            edge_pulse <= edge_d;
            load_err   <= err_d;
            at_lo      <= (count_d == LO_N);
            at_hi      <= (count_d == HI_N);
        end
    end

endmodule

// File: tb/tb_stride_counter.sv
// Bench for stride_counter: directed vector table, random run against a reference model, second geometry.
module tb_stride_counter;

    localparam int LO  = 1;
    localparam int HI  = 15;
    localparam int ST  = 2;
    localparam int HI2 = 30;

    logic       clk = 1'b0;
    logic       reset, en, dir, load;
    logic [1:0] mode;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       edge_pulse, at_hi, at_lo, load_err;

    logic       reset2, en2, dir2, load2;
    logic [1:0] mode2;
    logic [4:0] load_val2;
    logic [4:0] count2;
    logic       edge2, at_hi2, at_lo2, load_err2;

    always #5 clk = ~clk;

    stride_counter #(.WIDTH(4), .START(1), .STEP(2)) dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_val(load_val), .count(count), .edge_pulse(edge_pulse),
        .at_hi(at_hi), .at_lo(at_lo), .load_err(load_err)
    );

    stride_counter #(.WIDTH(5), .START(0), .STEP(3)) dut2 (
        .clk(clk), .reset(reset2), .en(en2), .dir(dir2), .mode(mode2), .load(load2),
        .load_val(load_val2), .count(count2), .edge_pulse(edge2),
        .at_hi(at_hi2), .at_lo(at_lo2), .load_err(load_err2)
    );

    typedef struct {
        bit rst;
        bit ld;
        bit e;
        bit di;
        int md;
        int lv;
        int exp_cnt;
        bit exp_edge;
        bit exp_err;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad   = 0;

    // Reference model state for the default-geometry instance.
    int m_cnt = LO;
    bit m_dir = 1'b1;
    bit m_edge = 1'b0;
    bit m_err = 1'b0;

    task automatic add(input bit r, input bit ld, input bit e, input bit di, input int md,
                       input int lv, input int c, input bit eg, input bit er);
        vec_t v;
        v.rst = r; v.ld = ld; v.e = e; v.di = di; v.md = md; v.lv = lv;
        v.exp_cnt = c; v.exp_edge = eg; v.exp_err = er;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string tag, input int c, input bit eg, input bit er);
        chk({tag, ".count"}, int'(count), c);
        chk({tag, ".edge"}, int'(edge_pulse), int'(eg));
        chk({tag, ".at_hi"}, int'(at_hi), int'(c == HI));
        chk({tag, ".at_lo"}, int'(at_lo), int'(c == LO));
        chk({tag, ".load_err"}, int'(load_err), int'(er));
    endtask

    task automatic model_step(input bit r, input bit ld, input bit e, input bit di,
                              input int md, input int lv);
        int a;
        int nx;
        bit dd;
        m_edge = 1'b0;
        m_err  = 1'b0;
        if (!r) begin
            m_cnt = LO;
            m_dir = 1'b1;
        end else if (ld) begin
            if (lv < LO) a = LO;
            else if (lv > HI) a = HI;
            else a = LO + ((lv - LO) / ST) * ST;
            m_err = (a != lv);
            m_cnt = a;
            m_dir = di;
        end else if (e) begin
            dd = (md == 2) ? m_dir : di;
            if (md != 2) m_dir = di;
            nx = dd ? m_cnt + ST : m_cnt - ST;
            if (nx >= LO && nx <= HI) begin
                m_cnt = nx;
            end else if (md == 1) begin
                m_cnt = m_cnt;
            end else if (md == 2) begin
                m_cnt  = dd ? m_cnt - ST : m_cnt + ST;
                m_dir  = !dd;
                m_edge = 1'b1;
            end else begin
                m_cnt  = dd ? LO : HI;
                m_edge = 1'b1;
            end
        end
    endtask

    task automatic drive(input bit r, input bit ld, input bit e, input bit di,
                         input int md, input int lv);
        @(negedge clk);
        reset = r; load = ld; en = e; dir = di; mode = 2'(md); load_val = 4'(lv);
        model_step(r, ld, e, di, md, lv);
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input bit r, input bit e, input bit di);
        @(negedge clk);
        reset2 = r; en2 = e; dir2 = di;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0; mode = 2'd0; load_val = '0;
        reset2 = 1'b0; en2 = 1'b0; dir2 = 1'b1; load2 = 1'b0; mode2 = 2'd0; load_val2 = '0;

        // Directed vectors: wrap, saturate, bounce, loads, load-vs-en, reset priority.
        add(0, 0, 0, 1, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 7; k++) add(1, 0, 1, 1, 0, 0, 1 + 2 * k, 0, 0);
        add(1, 0, 1, 1, 0, 0, 1, 1, 0);
        add(1, 1, 0, 1, 1, 13, 13, 0, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 1, 1, 1, 0, 15, 0, 0);
        add(1, 0, 1, 0, 1, 0, 13, 0, 0);
        add(1, 1, 0, 1, 2, 13, 13, 0, 0);
        add(1, 0, 1, 0, 2, 0, 15, 0, 0);
        add(1, 0, 1, 0, 2, 0, 13, 1, 0);
        for (int k = 0; k < 6; k++) add(1, 0, 1, 1, 2, 0, 11 - 2 * k, 0, 0);
        add(1, 0, 1, 0, 2, 0, 3, 1, 0);
        add(1, 1, 0, 1, 0, 6, 5, 0, 1);
        add(1, 1, 0, 1, 0, 0, 1, 0, 1);
        add(1, 1, 0, 1, 0, 9, 9, 0, 0);
        add(1, 1, 1, 1, 0, 4, 3, 0, 1);
        add(1, 0, 0, 1, 0, 0, 3, 0, 0);
        add(1, 1, 0, 1, 0, 11, 11, 0, 0);
        add(0, 1, 1, 1, 0, 6, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ld, tbl[i].e, tbl[i].di, tbl[i].md, tbl[i].lv);
            chk_dut($sformatf("vec%0d", i), tbl[i].exp_cnt, tbl[i].exp_edge, tbl[i].exp_err);
        end

        // Random run against the reference model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            chk_dut($sformatf("rnd%0d", i), m_cnt, m_edge, m_err);
        end

        // Second geometry: WIDTH=5, START=0, STEP=3, so HI=30.
        drive2(1'b0, 1'b0, 1'b1);
        chk("w5.reset.count", int'(count2), 0);
        chk("w5.reset.at_lo", int'(at_lo2), 1);
        chk("w5.reset.at_hi", int'(at_hi2), 0);
        for (int k = 1; k <= 10; k++) begin
            drive2(1'b1, 1'b1, 1'b1);
            chk($sformatf("w5.up%0d", k), int'(count2), 3 * k);
            chk($sformatf("w5.up%0d.edge", k), int'(edge2), 0);
        end
        chk("w5.at_hi", int'(at_hi2), 1);
        drive2(1'b1, 1'b1, 1'b1);
        chk("w5.wrap.count", int'(count2), 0);
        chk("w5.wrap.edge", int'(edge2), 1);
        drive2(1'b1, 1'b1, 1'b0);
        chk("w5.down_wrap.count", int'(count2), HI2);
        chk("w5.down_wrap.edge", int'(edge2), 1);
        chk("w5.down_wrap.at_hi", int'(at_hi2), 1);
        drive2(1'b1, 1'b1, 1'b0);
        chk("w5.down.count", int'(count2), HI2 - 3);
        chk("w5.down.edge", int'(edge2), 0);
        drive2(1'b1, 1'b0, 1'b1);
        chk("w5.hold.count", int'(count2), HI2 - 3);
        chk("w5.load_err", int'(load_err2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
